// File: rtl/cdr_tx_serializer.sv
// cdr_tx_serializer: frames payload bytes as preamble + sync word + data.
// The frames are sent as an oversampled NRZ bit stream. A signed line level
// is also produced for the CDR sample input.
// Optional build macro CDR_TX_SCRAMBLE_EN whitens DATA bits with PRBS7.

module cdr_tx_serializer #(
    parameter int         PREAMBLE_BITS = 16,
    parameter logic [7:0] SYNC_WORD     = 8'hD5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [3:0] osr,
    input  logic [6:0] amp,
    output logic       ser_out,
    output logic [7:0] level_out,
    output logic       bit_stb,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, SYNC, DATA} state_t;

    localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_BITS - 1);

    state_t     state, state_d;
    logic [3:0] bit_cnt, bit_cnt_d;
    logic [3:0] osr_q, osr_d;
    logic [5:0] bit_idx, bit_idx_d;
    logic [7:0] shift_reg, shift_d;
    logic       data_bit;
    logic       last_data_bit;

`ifdef CDR_TX_SCRAMBLE_EN
    logic [6:0] prbs, prbs_d;
    logic       prbs_fb;

    // Whitening bit for the current data bit
    always_comb begin
        prbs_fb  = prbs[6] ^ prbs[5];
        data_bit = shift_reg[~bit_idx[2:0]] ^ prbs_fb;
    end
`else
    // Payload goes out unmodified
    always_comb begin
        data_bit = shift_reg[~bit_idx[2:0]];
    end
`endif

    // Line outputs, bit strobe and handshake decoded from the current state
    always_comb begin
        busy          = (state != IDLE);
        bit_stb       = busy && (bit_cnt == osr_q - 4'd1);
        last_data_bit = (state == DATA) && (bit_idx == 6'd7) && bit_stb;
        tx_ready      = ena && rst_n && ((state == IDLE) || last_data_bit);
        case (state)
            PREAMBLE: ser_out = ~bit_idx[0];
            SYNC:     ser_out = SYNC_WORD[~bit_idx[2:0]];
            DATA:     ser_out = data_bit;
            default:  ser_out = 1'b0;
        endcase
        if (!busy)
            level_out = 8'd0;
        else if (ser_out)
            level_out = {1'b0, amp};
        else
            level_out = 8'd0 - {1'b0, amp};
    end

    // Next-state logic: bit timing, frame sequencing, byte loading and abort
    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift_reg;
        osr_d     = osr_q;
`ifdef CDR_TX_SCRAMBLE_EN
        prbs_d    = prbs;
`endif
        if (state == IDLE) begin
            if (tx_valid && tx_ready) begin
                state_d   = PREAMBLE;
                shift_d   = tx_data;
                osr_d     = (osr < 4'd2) ? 4'd2 : osr;
                bit_cnt_d = 4'd0;
                bit_idx_d = 6'd0;
            end
        end else if (!ena) begin
            state_d   = IDLE;
            shift_d   = 8'd0;
            bit_cnt_d = 4'd0;
            bit_idx_d = 6'd0;
        end else if (bit_stb) begin
            bit_cnt_d = 4'd0;
            bit_idx_d = bit_idx + 6'd1;
            case (state)
                PREAMBLE: begin
                    if (bit_idx == PRE_LAST) begin
                        state_d   = SYNC;
                        bit_idx_d = 6'd0;
                    end
                end
                SYNC: begin
                    if (bit_idx == 6'd7) begin
                        state_d   = DATA;
                        bit_idx_d = 6'd0;
`ifdef CDR_TX_SCRAMBLE_EN
                        prbs_d    = 7'h7F;
`endif
                    end
                end
                default: begin
`ifdef CDR_TX_SCRAMBLE_EN
                    prbs_d = {prbs[5:0], prbs_fb};
`endif
                    if (bit_idx == 6'd7) begin
                        bit_idx_d = 6'd0;
                        if (tx_valid && tx_ready) begin
                            shift_d = tx_data;
                        end else begin
                            state_d = IDLE;
                            shift_d = 8'd0;
                        end
                    end
                end
            endcase
        end else begin
            bit_cnt_d = bit_cnt + 4'd1;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            bit_idx   <= 6'd0;
            shift_reg <= 8'd0;
            osr_q     <= 4'd2;
`ifdef CDR_TX_SCRAMBLE_EN
            prbs      <= 7'd0;
`endif
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            bit_idx   <= bit_idx_d;
            shift_reg <= shift_d;
            osr_q     <= osr_d;
`ifdef CDR_TX_SCRAMBLE_EN
            prbs      <= prbs_d;
`endif
        end
    end

endmodule

// File: tb/tb_cdr_tx_serializer.sv
// Testbench for cdr_tx_serializer: directed frames plus randomized traffic.
// A bit-list reference model predicts every output on every cycle.

module tb_cdr_tx_serializer;

    localparam int         P  = 16;
    localparam logic [7:0] SW = 8'hD5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [3:0] osr = 4'd4;
    logic [6:0] amp = 7'd0;
    logic       ser_out;
    logic [7:0] level_out;
    logic       bit_stb;
    logic       busy;

    int total = 0;
    int bad = 0;

    // Statistics gathered from the DUT for directed literal checks
    int         busy_cycles = 0;
    int         stb_count = 0;
    int         odd_level = 0;
    int         ready_in_frame = 0;
    logic [7:0] last_bits = 8'd0;

    // Reference model state: the whole frame as a list of line bits
    bit         m_active = 1'b0;
    int         m_k = 0;
    int         m_osr = 2;
    bit         m_bits[$];
    logic [6:0] m_prbs = 7'h7F;

    logic [7:0] tx_q[$];

    cdr_tx_serializer #(.PREAMBLE_BITS(P), .SYNC_WORD(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .osr       (osr),
        .amp       (amp),
        .ser_out   (ser_out),
        .level_out (level_out),
        .bit_stb   (bit_stb),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_byte(input logic [7:0] b);
        bit d;
        bit fb;
        for (int i = 7; i >= 0; i--) begin
            d = b[i];
`ifdef CDR_TX_SCRAMBLE_EN
            fb = m_prbs[6] ^ m_prbs[5];
            m_prbs = {m_prbs[5:0], fb};
            d = d ^ fb;
`else
            fb = 1'b0;
            d = d ^ fb;
`endif
            m_bits.push_back(d);
        end
    endfunction

    // Single compare process: predict outputs from the model, check, then advance
    always @(negedge clk) begin : compare
        int         b;
        bit         e_ser, e_stb, e_rdy;
        logic [7:0] e_lvl;
        if (!rst_n) begin
            checkOutput("rst_busy", 32'(busy), 0);
            checkOutput("rst_ser", 32'(ser_out), 0);
            checkOutput("rst_stb", 32'(bit_stb), 0);
            checkOutput("rst_level", 32'(level_out), 0);
            checkOutput("rst_ready", 32'(tx_ready), 0);
            m_active = 1'b0;
        end else begin
            if (m_active) begin
                b     = m_k / m_osr;
                e_stb = (m_k % m_osr) == m_osr - 1;
                e_ser = m_bits[b];
                e_rdy = ena && (b >= P + 8) && (((b - P - 8) % 8) == 7) && e_stb;
                e_lvl = e_ser ? {1'b0, amp} : 8'd0 - {1'b0, amp};
            end else begin
                e_ser = 1'b0;
                e_stb = 1'b0;
                e_rdy = ena;
                e_lvl = 8'd0;
            end
            checkOutput("busy", 32'(busy), 32'(m_active));
            checkOutput("ser_out", 32'(ser_out), 32'(e_ser));
            checkOutput("bit_stb", 32'(bit_stb), 32'(e_stb));
            checkOutput("tx_ready", 32'(tx_ready), 32'(e_rdy));
            checkOutput("level_out", 32'(level_out), 32'(e_lvl));

            if (busy) busy_cycles++;
            if (busy && tx_ready) ready_in_frame++;
            if (busy && level_out != 8'h28 && level_out != 8'hD8) odd_level++;
            if (bit_stb) begin
                stb_count++;
                last_bits = {last_bits[6:0], ser_out};
            end

            if (!ena) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (tx_valid) begin
                    m_active = 1'b1;
                    m_k = 0;
                    m_osr = (osr < 2) ? 2 : int'(osr);
                    m_bits.delete();
                    for (int i = 0; i < P; i++) m_bits.push_back((i % 2) == 0);
                    for (int i = 7; i >= 0; i--) m_bits.push_back(SW[i]);
                    m_prbs = 7'h7F;
                    push_byte(tx_data);
                end
            end else begin
                if (e_rdy && tx_valid) push_byte(tx_data);
                m_k++;
                if (m_k == m_bits.size() * m_osr) m_active = 1'b0;
            end
        end
    end

    task automatic clear_stats();
        busy_cycles    = 0;
        stb_count      = 0;
        odd_level      = 0;
        ready_in_frame = 0;
    endtask

    // Offer every byte in tx_q back to back, then wait for the frame to end
    task automatic applyStimulus(input logic [3:0] o, input logic [6:0] a, input bit jitter);
        int   guard;
        logic hs;
        osr      = o;
        amp      = a;
        tx_valid = 1'b1;
        tx_data  = tx_q[0];
        guard    = 0;
        while (tx_q.size() > 0 && guard < 5000) begin
            @(negedge clk);
            hs = tx_ready;
            @(posedge clk);
            #1;
            guard++;
            if (hs) begin
                void'(tx_q.pop_front());
                if (tx_q.size() > 0) begin
                    tx_data = tx_q[0];
                end else begin
                    tx_valid = 1'b0;
                    tx_data  = 8'($urandom);
                end
            end
            if (jitter) begin
                ena = ($urandom_range(0, 99) != 0);
                amp = 7'($urandom);
                osr = 4'($urandom);
            end
        end
        if (guard >= 5000) begin
            checkOutput("handshake_timeout", 32'(tx_q.size()), 0);
            tx_q.delete();
            tx_valid = 1'b0;
        end
        guard = 0;
        while (busy && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
            if (jitter) begin
                ena = ($urandom_range(0, 99) != 0);
                amp = 7'($urandom);
            end
        end
        if (guard >= 5000) checkOutput("busy_timeout", 32'(busy), 0);
        ena = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_level", 32'(level_out), 0);
        rst_n = 1'b1;
        ena   = 1'b1;
        @(posedge clk);
        #1;

        // Single byte 0xA5 at osr=4, amp=40
        clear_stats();
        tx_q = '{8'hA5};
        applyStimulus(4'd4, 7'd40, 1'b0);
        checkOutput("a5_busy_clocks", 32'(busy_cycles), 128);
        checkOutput("a5_stb_count", 32'(stb_count), 32);
        checkOutput("a5_level_values", 32'(odd_level), 0);
        checkOutput("a5_ready_pulses", 32'(ready_in_frame), 1);
`ifdef CDR_TX_SCRAMBLE_EN
        checkOutput("a5_data_bits", 32'(last_bits), 32'h0A7);
`else
        checkOutput("a5_data_bits", 32'(last_bits), 32'h0A5);
`endif

        // Two bytes back to back at osr=2
        clear_stats();
        tx_q = '{8'h3C, 8'hC3};
        applyStimulus(4'd2, 7'd100, 1'b0);
        checkOutput("b2b_busy_clocks", 32'(busy_cycles), 80);
        checkOutput("b2b_stb_count", 32'(stb_count), 40);
        checkOutput("b2b_ready_pulses", 32'(ready_in_frame), 2);

        // osr 0 and 1 clamp to two clocks per bit
        clear_stats();
        tx_q = '{8'h81};
        applyStimulus(4'd0, 7'd5, 1'b0);
        checkOutput("osr0_busy_clocks", 32'(busy_cycles), 64);
        clear_stats();
        tx_q = '{8'h7E};
        applyStimulus(4'd1, 7'd0, 1'b0);
        checkOutput("osr1_busy_clocks", 32'(busy_cycles), 64);

        // Payload 0x00 shows the scrambler pattern (or plain zeros)
        clear_stats();
        tx_q = '{8'h00};
        applyStimulus(4'd3, 7'd64, 1'b0);
`ifdef CDR_TX_SCRAMBLE_EN
        checkOutput("zero_data_bits", 32'(last_bits), 32'h002);
`else
        checkOutput("zero_data_bits", 32'(last_bits), 32'h000);
`endif

        // Drop ena during SYNC, then a fresh frame starts from the preamble
        osr      = 4'd2;
        amp      = 7'd33;
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (36) @(posedge clk);
        #1;
        ena = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_level", 32'(level_out), 0);
        checkOutput("abort_ser", 32'(ser_out), 0);
        checkOutput("abort_ready", 32'(tx_ready), 0);
        ena = 1'b1;
        @(posedge clk);
        #1;
        clear_stats();
        tx_q = '{8'h96};
        applyStimulus(4'd2, 7'd77, 1'b0);
        checkOutput("reenable_busy_clocks", 32'(busy_cycles), 64);

        // Asynchronous reset in the middle of DATA
        osr      = 4'd2;
        tx_valid = 1'b1;
        tx_data  = 8'hF0;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (60) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", 32'(busy), 0);
        checkOutput("async_rst_level", 32'(level_out), 0);
        checkOutput("async_rst_ser", 32'(ser_out), 0);
        checkOutput("async_rst_ready", 32'(tx_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_stats();
        tx_q = '{8'h1E};
        applyStimulus(4'd3, 7'd20, 1'b0);
        checkOutput("post_rst_busy_clocks", 32'(busy_cycles), 96);

        // Randomized traffic with mid-frame osr/amp changes and enable drops
        for (int f = 0; f < 20; f++) begin
            int n;
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
            applyStimulus(4'($urandom_range(0, 7)), 7'($urandom), (f % 2) == 1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
